// File: rtl/flappy_pkg.sv
// Shared constants for the flappy game pipeline: game state encoding and
// default sizing that the renderer flash logic also relies on.
package flappy_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_DYING   = 2'd2;
    localparam logic [1:0] ST_OVER    = 2'd3;

    localparam int SCORE_W_DEF      = 8;
    localparam int DEATH_FRAMES_DEF = 30;
    localparam int CNT_W_DEF        = 5;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous push-button followed by a
// registered rising-edge detector; rise pulses 3 clocks after the button rises.
module btn_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic rise_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            rise_reg  <= sync2_reg & ~prev_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/game_state_ctrl.sv
// Game-level FSM: per-frame hit latch, death flash counter, saturating score.
// Define GAME_HISCORE_EN to add the hiscore register and output port.
module game_state_ctrl
    import flappy_pkg::*;
#(
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int DEATH_FRAMES = DEATH_FRAMES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               collide,
    input  logic               flap_btn,
    input  logic               pipe_passed,
    output logic [1:0]         state,
    output logic               flap_pulse,
    output logic               freeze,
    output logic               game_over,
`ifdef GAME_HISCORE_EN
    output logic [SCORE_W-1:0] hiscore,
`endif
    output logic [SCORE_W-1:0] score
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEATH_FRAMES - 1);

    logic               flap_rise;
    logic [1:0]         state_reg, state_next;
    logic               hit_reg, hit_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic               pulse_reg;
    logic               frame_hit;

    btn_sync_edge u_flap_sync (
        .clock (clock),
        .reset (reset),
        .btn   (flap_btn),
        .rise  (flap_rise)
    );

    // A collide arriving in the tick cycle still belongs to the closing frame.
    assign frame_hit = hit_reg | collide;

    always_comb begin
        state_next = state_reg;
        hit_next   = frame_tick ? 1'b0 : hit_reg;
        cnt_next   = cnt_reg;
        score_next = score_reg;
        case (state_reg)
            ST_IDLE: begin
                if (flap_rise) begin
                    state_next = ST_PLAYING;
                    score_next = '0;
                end
            end
            ST_PLAYING: begin
                if (pipe_passed && score_reg != SCORE_MAX) begin
                    score_next = score_reg + 1'b1;
                end
                if (frame_tick && frame_hit) begin
                    state_next = ST_DYING;
                    cnt_next   = '0;
                end else if (!frame_tick && collide) begin
                    hit_next = 1'b1;
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_next = ST_OVER;
                    end
                end
            end
            ST_OVER: begin
                if (flap_rise) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            hit_reg   <= 1'b0;
            cnt_reg   <= '0;
            score_reg <= '0;
            pulse_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            hit_reg   <= hit_next;
            cnt_reg   <= cnt_next;
            score_reg <= score_next;
            pulse_reg <= flap_rise && (state_reg == ST_IDLE || state_reg == ST_PLAYING);
        end
    end

`ifdef GAME_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            hiscore_reg <= '0;
        end else if (state_reg == ST_DYING && state_next == ST_OVER
                     && score_reg > hiscore_reg) begin
            hiscore_reg <= score_reg;
        end
    end

    assign hiscore = hiscore_reg;
`endif

    assign state      = state_reg;
    assign flap_pulse = pulse_reg;
    assign freeze     = (state_reg != ST_PLAYING);
    assign game_over  = (state_reg == ST_OVER);
    assign score      = score_reg;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural game model.
module tb_game_state_ctrl;

    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;
    localparam int DF   = 30;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic          collide = 1'b0;
    logic          flap_btn = 1'b0;
    logic          pipe_passed = 1'b0;
    logic [1:0]    state;
    logic          flap_pulse;
    logic          freeze;
    logic          game_over;
    logic [SW-1:0] score;
`ifdef GAME_HISCORE_EN
    logic [SW-1:0] hiscore;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    game_state_ctrl #(.SCORE_W(SW), .DEATH_FRAMES(DF), .CNT_W(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .collide     (collide),
        .flap_btn    (flap_btn),
        .pipe_passed (pipe_passed),
        .state       (state),
        .flap_pulse  (flap_pulse),
        .freeze      (freeze),
        .game_over   (game_over),
`ifdef GAME_HISCORE_EN
        .hiscore     (hiscore),
`endif
        .score       (score)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: phase 0=idle 1=playing 2=dying 3=over.
    int   m_state = 0, m_score = 0, m_cnt = 0, m_hi = 0;
    bit   m_pulse = 0, m_latch = 0, m_rise, m_tick_hit;
    int   m_prev;
    bit [4:0] hist = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_state = 0; m_score = 0; m_cnt = 0; m_hi = 0;
            m_pulse = 0; m_latch = 0; hist = '0;
        end else begin
            // Button sampled at this edge is hist[0]; the edge detector sees it 3 edges later.
            hist       = {hist[3:0], flap_btn};
            m_rise     = hist[3] & ~hist[4];
            m_pulse    = m_rise && (m_state == 0 || m_state == 1);
            m_tick_hit = frame_tick && (m_latch || collide);
            m_prev     = m_state;
            case (m_state)
                0: if (m_rise) begin m_state = 1; m_score = 0; end
                1: begin
                    if (pipe_passed) m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
                    if (m_tick_hit) begin m_state = 2; m_cnt = 0; end
                end
                2: if (frame_tick) begin
                    if (m_cnt == DF - 1) begin
                        m_state = 3;
                        if (m_score > m_hi) m_hi = m_score;
                    end
                    m_cnt = m_cnt + 1;
                end
                default: if (m_rise) m_state = 0;
            endcase
            m_latch = frame_tick ? 1'b0 : (m_latch || (collide && m_prev == 1));
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("state", int'(state), m_state);
            chk("flap_pulse", int'(flap_pulse), int'(m_pulse));
            chk("freeze", int'(freeze), int'(m_state != 1));
            chk("game_over", int'(game_over), int'(m_state == 3));
            chk("score", int'(score), m_score);
`ifdef GAME_HISCORE_EN
            chk("hiscore", int'(hiscore), m_hi);
`endif
        end
    end

    task automatic cyc(input bit t, input bit c, input bit p);
        frame_tick = t; collide = c; pipe_passed = p;
        @(posedge clock); #1;
        frame_tick = 1'b0; collide = 1'b0; pipe_passed = 1'b0;
    endtask

    task automatic press(input int hold);
        flap_btn = 1'b1;
        repeat (hold) cyc(0, 0, 0);
        flap_btn = 1'b0;
        repeat (4) cyc(0, 0, 0);
    endtask

    task automatic die_out();
        for (int i = 0; i < DF; i++) begin
            cyc(1, 0, 0);
            cyc(0, 0, 0);
        end
    endtask

    int seen, at;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk_en = 1'b1;
        chk("rst_state", int'(state), 0);
        chk("rst_freeze", int'(freeze), 1);
        chk("rst_score", int'(score), 0);
        chk("rst_pulse", int'(flap_pulse), 0);
        reset = 1'b0;

        // Flap from idle: exactly one pulse, 4 clocks after the rise.
        flap_btn = 1'b1;
        seen = 0; at = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (flap_pulse) begin seen++; at = i; end
        end
        flap_btn = 1'b0;
        chk("t1_pulse_count", seen, 1);
        chk("t1_pulse_at", at, 4);
        chk("t1_state", int'(state), 1);
        chk("t1_score", int'(score), 0);

        // Game A: score 4, collide mid-frame, 30 flash frames to OVER.
        repeat (3) begin cyc(0, 0, 1); cyc(0, 0, 0); end
        chk("t2_score", int'(score), 3);
        chk("t2_freeze", int'(freeze), 0);
        cyc(1, 0, 0);
        chk("t2_clean_tick", int'(state), 1);
        cyc(0, 0, 1);
        chk("t2_score4", int'(score), 4);
        cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 0);
        chk("t3_pre_tick", int'(state), 1);
        cyc(1, 0, 0);
        chk("t3_dying", int'(state), 2);
        cyc(0, 0, 1);
        chk("t3_pipe_ignored", int'(score), 4);
        for (int i = 0; i < DF - 1; i++) begin cyc(1, 0, 0); cyc(0, 0, 0); end
        chk("t3_still_dying", int'(state), 2);
        cyc(1, 0, 0);
        chk("t3_over", int'(state), 3);
        chk("t3_game_over", int'(game_over), 1);
`ifdef GAME_HISCORE_EN
        chk("t6_hiscore_a", int'(hiscore), 4);
`endif
        press(6);
        chk("t4_over_to_idle", int'(state), 0);
        chk("t4_score_hold", int'(score), 4);

        // Collide outside PLAYING never latches.
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        chk("t5_idle_collide", int'(state), 0);

        // flap_rise coincides with a tick carrying collide: start, no hit.
        flap_btn = 1'b1;
        repeat (3) cyc(0, 0, 0);
        cyc(1, 1, 0);
        flap_btn = 1'b0;
        chk("t5_start_on_tick", int'(state), 1);
        chk("t5_score_cleared", int'(score), 0);
        repeat (3) cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("t5_no_stale_hit", int'(state), 1);

        // Game B: score 2, collide in the tick cycle itself.
        repeat (2) begin cyc(0, 0, 1); cyc(0, 0, 0); end
        cyc(1, 1, 0);
        chk("t5_same_clock_hit", int'(state), 2);
        die_out();
        chk("t6_over_b", int'(state), 3);
        chk("t6_score_b", int'(score), 2);
`ifdef GAME_HISCORE_EN
        chk("t6_hiscore_kept", int'(hiscore), 4);
`endif

        // Reset in the middle of DYING.
        press(6);
        press(6);
        cyc(0, 0, 1);
        cyc(1, 1, 0);
        repeat (5) cyc(1, 0, 0);
        reset = 1'b1;
        cyc(0, 0, 0);
        reset = 1'b0;
        chk("t6_rst_state", int'(state), 0);
        chk("t6_rst_score", int'(score), 0);
`ifdef GAME_HISCORE_EN
        chk("t6_rst_hiscore", int'(hiscore), 0);
`endif

        // Saturation.
        press(6);
        repeat (SMAX + 5) cyc(0, 0, 1);
        chk("t4_saturated", int'(score), SMAX);

        // Randomized play against the model.
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 9) == 0) flap_btn = ~flap_btn;
            reset       = ($urandom_range(0, 799) == 0);
            frame_tick  = ($urandom_range(0, 7) == 0);
            collide     = ($urandom_range(0, 39) == 0);
            pipe_passed = ($urandom_range(0, 5) == 0);
            @(posedge clock); #1;
        end
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
